// File: rtl/msp430_spram_loader_pkg.sv
// Shared types and constants for the SPRAM boot-image loader.
package msp430_spram_loader_pkg;

    localparam int unsigned CMD_NODE_W = 12;
    localparam int unsigned HALF_W     = 16;

    typedef enum logic [3:0] {
        OP_WRITE   = 4'h1,
        OP_RELEASE = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        S_CMD  = 3'd0,
        S_AHI  = 3'd1,
        S_ALO  = 3'd2,
        S_LEN  = 3'd3,
        S_DATA = 3'd4
    } state_e;

endpackage

// File: rtl/msp430_spram_loader_if.sv
// 16-bit valid/ready command stream feeding the loader (host/GLIP side).
interface msp430_spram_loader_if;
    import msp430_spram_loader_pkg::*;

    logic [HALF_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);

endinterface

// File: rtl/msp430_spram_port_mux.sv
// Selects between core and loader RAM ports per node; loader owns the RAMs while hold is set.
module msp430_spram_port_mux #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned NODES = 8
) (
    input  logic                hold,
    input  logic [NODES*AW-1:0] core_addr_i,
    input  logic [NODES*DW-1:0] core_din_i,
    input  logic [NODES-1:0]    core_en_i,
    input  logic [NODES-1:0]    core_we_i,
    input  logic [NODES*AW-1:0] ld_addr,
    input  logic [NODES*DW-1:0] ld_din,
    input  logic [NODES-1:0]    ld_en,
    input  logic [NODES-1:0]    ld_we,
    output logic [NODES*AW-1:0] ram_addr_o,
    output logic [NODES*DW-1:0] ram_din_o,
    output logic [NODES-1:0]    ram_en_o,
    output logic [NODES-1:0]    ram_we_o
);

    always_comb begin
        if (hold) begin
            ram_addr_o = ld_addr;
            ram_din_o  = ld_din;
            ram_en_o   = ld_en;
            ram_we_o   = ld_we;
        end else begin
            ram_addr_o = core_addr_i;
            ram_din_o  = core_din_i;
            ram_en_o   = core_en_i;
            ram_we_o   = core_we_i;
        end
    end

endmodule

// File: rtl/msp430_spram_loader.sv
// Boot-image loader: parses a halfword command stream and writes words into per-node RAMs,
// holding the cores in reset until RELEASE, then passes core RAM traffic straight through.
module msp430_spram_loader
    import msp430_spram_loader_pkg::*;
#(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned NODES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    msp430_spram_loader_if.slave cmd,
    input  logic [NODES*AW-1:0]  core_addr_i,
    input  logic [NODES*DW-1:0]  core_din_i,
    input  logic [NODES-1:0]     core_en_i,
    input  logic [NODES-1:0]     core_we_i,
    output logic [NODES*DW-1:0]  core_dout_o,
    output logic [NODES*AW-1:0]  ram_addr_o,
    output logic [NODES*DW-1:0]  ram_din_o,
    output logic [NODES-1:0]     ram_en_o,
    output logic [NODES-1:0]     ram_we_o,
    input  logic [NODES*DW-1:0]  ram_dout_i,
    output logic                 hold_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int unsigned HW   = DW / HALF_W;
    localparam int unsigned HW_W = (HW > 1) ? $clog2(HW) : 1;

    state_e                state;
    logic [CMD_NODE_W-1:0] node_q;
    logic                  node_ok_q;
    logic [HALF_W-1:0]     ahi_q;
    logic [AW-1:0]         addr_q;
    logic [15:0]           len_q;
    logic [HW_W-1:0]       hw_idx;
    logic [DW-1:0]         word_sr;
    logic                  hold_q;
    logic                  err_q;

    logic                  wr_en_q;
    logic [CMD_NODE_W-1:0] wr_node_q;
    logic [AW-1:0]         wr_addr_q;
    logic [DW-1:0]         wr_data_q;

    logic                  xfer;
    logic [3:0]            cmd_op;
    logic [CMD_NODE_W-1:0] cmd_node;
    logic                  node_in_range;
    logic                  last_hw;
    logic [DW+HALF_W-1:0]  word_cat;
    logic [DW-1:0]         word_next;
    logic [AW+31:0]        addr_ext;
    logic [AW-1:0]         addr_load;

    assign cmd.in_ready = 1'b1;
    assign xfer         = cmd.in_valid & cmd.in_ready;
    assign cmd_op       = cmd.in_data[15:12];
    assign cmd_node     = cmd.in_data[CMD_NODE_W-1:0];
    assign node_in_range = {1'b0, cmd_node} < (CMD_NODE_W + 1)'(NODES);
    assign last_hw      = (hw_idx == HW_W'(HW - 1));

    // Concatenation widths keep the shift and the address truncate/extend valid for any DW/AW.
    assign word_cat  = {word_sr, cmd.in_data};
    assign word_next = word_cat[DW-1:0];
    assign addr_ext  = {{AW{1'b0}}, ahi_q, cmd.in_data};
    assign addr_load = addr_ext[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CMD;
            node_q    <= '0;
            node_ok_q <= 1'b0;
            ahi_q     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            hw_idx    <= '0;
            word_sr   <= '0;
            hold_q    <= 1'b1;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_node_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (xfer) begin
                case (state)
                    S_CMD: begin
                        if (cmd_op == OP_WRITE) begin
                            state     <= S_AHI;
                            hold_q    <= 1'b1;
                            node_q    <= cmd_node;
                            node_ok_q <= node_in_range;
                            if (!node_in_range) err_q <= 1'b1;
                        end else if (cmd_op == OP_RELEASE) begin
                            hold_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    S_AHI: begin
                        ahi_q <= cmd.in_data;
                        state <= S_ALO;
                    end
                    S_ALO: begin
                        addr_q <= addr_load;
                        state  <= S_LEN;
                    end
                    S_LEN: begin
                        len_q  <= cmd.in_data;
                        hw_idx <= '0;
                        state  <= (cmd.in_data == 16'd0) ? S_CMD : S_DATA;
                    end
                    S_DATA: begin
                        word_sr <= word_next;
                        if (last_hw) begin
                            // Out-of-range frames are still consumed, just never enabled.
                            hw_idx    <= '0;
                            wr_en_q   <= node_ok_q;
                            wr_node_q <= node_q;
                            wr_addr_q <= addr_q;
                            wr_data_q <= word_next;
                            addr_q    <= addr_q + 1'b1;
                            len_q     <= len_q - 16'd1;
                            if (len_q == 16'd1) state <= S_CMD;
                        end else begin
                            hw_idx <= hw_idx + 1'b1;
                        end
                    end
                    default: state <= S_CMD;
                endcase
            end
        end
    end

    logic [NODES-1:0]    ld_en;
    logic [NODES*AW-1:0] ld_addr;
    logic [NODES*DW-1:0] ld_din;

    always_comb begin
        ld_en = '0;
        for (int unsigned n = 0; n < NODES; n++) begin
            ld_en[n] = wr_en_q && (wr_node_q == CMD_NODE_W'(n));
        end
    end

    assign ld_addr = {NODES{wr_addr_q}};
    assign ld_din  = {NODES{wr_data_q}};

    msp430_spram_port_mux #(
        .AW    (AW),
        .DW    (DW),
        .NODES (NODES)
    ) u_port_mux (
        .hold        (hold_q),
        .core_addr_i (core_addr_i),
        .core_din_i  (core_din_i),
        .core_en_i   (core_en_i),
        .core_we_i   (core_we_i),
        .ld_addr     (ld_addr),
        .ld_din      (ld_din),
        .ld_en       (ld_en),
        .ld_we       (ld_en),
        .ram_addr_o  (ram_addr_o),
        .ram_din_o   (ram_din_o),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o)
    );

    assign core_dout_o = ram_dout_i;
    assign hold_o      = hold_q;
    assign busy_o      = (state != S_CMD);
    assign err_o       = err_q;

endmodule
